// File: rtl/frame_accumulator.sv
// frame_accumulator
//
// Sums a stream of unsigned samples over a fixed frame of N = 2**LOG2_LEN
// accepted samples and emits one registered frame total per completed frame.
// The frame total is held on odata until the next completion; ovalid pulses
// for one cycle with each new total.
//
// Optional build macro: FRAME_ACC_MEAN_EN
//   defined   -> odata carries the truncating frame mean, sum >> LOG2_LEN
//   undefined -> odata carries the full frame sum (default)
//
// The accumulator is WL+LOG2_LEN bits wide, which holds N*(2**WL-1)
// exactly, so no overflow or saturation handling exists.
// LOG2_LEN must be at least 1; the smallest frame is two samples.

module frame_accumulator #(
    parameter int WL       = 9,
    parameter int LOG2_LEN = 4
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iEN,
    input  logic [WL-1:0]            idata,
    input  logic                     iclear,
    output logic [WL+LOG2_LEN-1:0]   odata,
    output logic                     ovalid,
    output logic [LOG2_LEN-1:0]      ocount,
    output logic                     obusy
);

    localparam int AW = WL + LOG2_LEN;

    localparam logic [LOG2_LEN-1:0] CNT_ZERO = '0;
    localparam logic [LOG2_LEN-1:0] CNT_ONE  = LOG2_LEN'(1);
    localparam logic [LOG2_LEN-1:0] CNT_LAST = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t              state_q,  state_d;
    logic [AW-1:0]       acc_q,    acc_d;
    logic [LOG2_LEN-1:0] cnt_q,    cnt_d;
    logic [AW-1:0]       result_q, result_d;
    logic                valid_q,  valid_d;

    logic [AW-1:0]       sampleExt;
    logic [AW-1:0]       sumFull;
    logic [AW-1:0]       frameOut;
    logic                lastSample;

    assign sampleExt  = AW'(idata);
    assign sumFull    = acc_q + sampleExt;
    assign lastSample = (cnt_q == CNT_LAST);

`ifdef FRAME_ACC_MEAN_EN
    assign frameOut = sumFull >> LOG2_LEN;
`else
    assign frameOut = sumFull;
`endif

    // Register all state; an asynchronous reset drops any partial frame.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= CNT_ZERO;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    // Next state: clear beats a sample, the last sample closes the frame.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = 1'b0;

        if (iclear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = CNT_ZERO;
        end else if (iEN) begin
            if (lastSample) begin
                state_d  = IDLE;
                acc_d    = '0;
                cnt_d    = CNT_ZERO;
                result_d = frameOut;
                valid_d  = 1'b1;
            end else begin
                state_d = ACCUM;
                acc_d   = sumFull;
                cnt_d   = cnt_q + CNT_ONE;
            end
        end
    end

    assign odata  = result_q;
    assign ovalid = valid_q;
    assign ocount = cnt_q;
    assign obusy  = (state_q == ACCUM);

endmodule

// File: tb/tb_frame_accumulator.sv
// tb_frame_accumulator
//
// Drives frame_accumulator with WL=9, LOG2_LEN=2 (N=4): directed frames
// followed by a randomized stream. A frame-level reference model (a queue
// of the samples in the open frame) predicts every output after each edge.
// Follows FRAME_ACC_MEAN_EN in the same way the design does.

module tb_frame_accumulator;

    localparam int WLP = 9;
    localparam int LGP = 2;
    localparam int NP  = 1 << LGP;

`ifdef FRAME_ACC_MEAN_EN
    localparam bit MEAN = 1'b1;
`else
    localparam bit MEAN = 1'b0;
`endif

    logic               iCLK;
    logic               iRST;
    logic               iEN;
    logic [WLP-1:0]     idata;
    logic               iclear;
    logic [WLP+LGP-1:0] odata;
    logic               ovalid;
    logic [LGP-1:0]     ocount;
    logic               obusy;

    int errors = 0;
    int checks = 0;

    int frameQ[$];
    int expData  = 0;
    int expValid = 0;
    int validPulses = 0;

    frame_accumulator #(
        .WL       (WLP),
        .LOG2_LEN (LGP)
    ) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iEN    (iEN),
        .idata  (idata),
        .iclear (iclear),
        .odata  (odata),
        .ovalid (ovalid),
        .ocount (ocount),
        .obusy  (obusy)
    );

    // Free-running clock, 10 time units per period.
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Compare one observed value with its expected value and count it.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Compare every output against the reference model.
    task automatic checkAll(input string tag);
        checkOutput({tag, ".odata"},  int'(odata),  expData);
        checkOutput({tag, ".ovalid"}, int'(ovalid), expValid);
        checkOutput({tag, ".ocount"}, int'(ocount), frameQ.size());
        checkOutput({tag, ".obusy"},  int'(obusy),  int'(frameQ.size() != 0));
    endtask

    // Reference model: collect samples; a full frame yields its sum or mean.
    task automatic modelStep(input bit en, input int data, input bit clr);
        int s;
        expValid = 0;
        if (clr) begin
            frameQ.delete();
        end else if (en) begin
            frameQ.push_back(data);
            if (frameQ.size() == NP) begin
                s = 0;
                foreach (frameQ[i]) s += frameQ[i];
                expData  = MEAN ? (s / NP) : s;
                expValid = 1;
                validPulses++;
                frameQ.delete();
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, check just after the edge.
    task automatic applyStimulus(input bit en, input int data, input bit clr, input string tag);
        iEN    = en;
        idata  = data[WLP-1:0];
        iclear = clr;
        @(posedge iCLK);
        modelStep(en, data, clr);
        #1;
        checkAll(tag);
    endtask

    // Asynchronous reset pulse in mid-cycle; outputs must clear before the next edge.
    task automatic resetPulse(input string tag);
        iEN    = 1'b0;
        iclear = 1'b0;
        iRST   = 1'b1;
        #2;
        frameQ.delete();
        expData  = 0;
        expValid = 0;
        checkAll(tag);
        iRST = 1'b0;
    endtask

    initial begin
        int pulsesBefore;
        int heldData;

        iRST   = 1'b1;
        iEN    = 1'b0;
        idata  = '0;
        iclear = 1'b0;
        #12;
        checkAll("rst0");
        iRST = 1'b0;

        // Contiguous frame 10,20,30,40
        applyStimulus(1, 10, 0, "c1");
        checkOutput("c1.cnt", int'(ocount), 1);
        applyStimulus(1, 20, 0, "c2");
        checkOutput("c2.cnt", int'(ocount), 2);
        applyStimulus(1, 30, 0, "c3");
        checkOutput("c3.cnt", int'(ocount), 3);
        applyStimulus(1, 40, 0, "c4");
        checkOutput("c4.cnt", int'(ocount), 0);
        checkOutput("c4.valid", int'(ovalid), 1);
        checkOutput("c4.sum", int'(odata), MEAN ? 25 : 100);
        applyStimulus(0, 0, 0, "cIdle");
        checkOutput("cIdle.valid", int'(ovalid), 0);
        checkOutput("cIdle.hold", int'(odata), MEAN ? 25 : 100);

        // Gapped frame 1,(idle x3),2,(idle),3,4
        pulsesBefore = validPulses;
        applyStimulus(1, 1, 0, "g1");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, "gGap");
        checkOutput("gGap.cnt", int'(ocount), 1);
        applyStimulus(1, 2, 0, "g2");
        applyStimulus(0, 0, 0, "gGap2");
        applyStimulus(1, 3, 0, "g3");
        applyStimulus(1, 4, 0, "g4");
        checkOutput("g4.sum", int'(odata), MEAN ? 2 : 10);
        checkOutput("g.pulses", validPulses - pulsesBefore, 1);
        applyStimulus(0, 0, 0, "gIdle");

        // Maximum input
        for (int i = 0; i < NP; i++) applyStimulus(1, 511, 0, "max");
        checkOutput("max.sum", int'(odata), MEAN ? 511 : 2044);
        applyStimulus(0, 0, 0, "maxIdle");

        // Frame abort with a simultaneous sample
        heldData = MEAN ? 511 : 2044;
        applyStimulus(1, 5, 0, "clr5");
        applyStimulus(1, 6, 0, "clr6");
        applyStimulus(1, 99, 1, "clrHit");
        checkOutput("clrHit.cnt", int'(ocount), 0);
        checkOutput("clrHit.hold", int'(odata), heldData);
        applyStimulus(1, 1, 0, "clrA");
        applyStimulus(1, 2, 0, "clrB");
        applyStimulus(1, 3, 0, "clrC");
        checkOutput("clrC.hold", int'(odata), heldData);
        applyStimulus(1, 4, 0, "clrD");
        checkOutput("clrD.sum", int'(odata), MEAN ? 2 : 10);

        // Clear on the completing sample
        applyStimulus(1, 8, 0, "ccA");
        applyStimulus(1, 8, 0, "ccB");
        applyStimulus(1, 8, 0, "ccC");
        applyStimulus(1, 8, 1, "ccD");
        checkOutput("ccD.valid", int'(ovalid), 0);
        checkOutput("ccD.hold", int'(odata), MEAN ? 2 : 10);

        // Back-to-back frames 1..8
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, i, 0, "b2b");
            if (i == 4) checkOutput("b2b.first", int'(odata), MEAN ? 2 : 10);
            if (i == 5) checkOutput("b2b.gapless", int'(ocount), 1);
            if (i == 8) checkOutput("b2b.second", int'(odata), MEAN ? 6 : 26);
        end

        // Reset mid-frame then a fresh frame
        applyStimulus(1, 7, 0, "r7a");
        applyStimulus(1, 7, 0, "r7b");
        resetPulse("rstMid");
        for (int i = 0; i < NP; i++) applyStimulus(1, 1, 0, "r1");
        checkOutput("r1.sum", int'(odata), MEAN ? 1 : 4);
        applyStimulus(0, 0, 0, "rIdle");

        // Randomized stream
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                resetPulse("rndRst");
            end else begin
                applyStimulus($urandom_range(0, 3) != 0,
                              int'($urandom_range(0, 511)),
                              $urandom_range(0, 24) == 0,
                              "rnd");
            end
        end
        applyStimulus(0, 0, 0, "end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
